ahb_op_sequencer: RTL

AHB-lite master that runs one complete ALU or multiplier operation per request on the system's slave peripherals. It replaces the dummy RISC master as the master 0 bus source in front of `ahb_lite_interconnect`. Per command it writes operand A, operand B and control/start, polls the status register until the done bit is set, reads the result, and returns it on a valid/ready response port. It uses single, non-pipelined transfers and reports bus errors and poll timeouts.

---
 rtl/ahb_op_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_op_sequencer.sv
// AHB-lite master that runs one ALU/multiplier operation per request:
// write A, write B, write CTRL, poll STAT until done, read RES, respond.
module ahb_op_sequencer #(
    parameter int unsigned       W_ADDR   = 32,
    parameter int unsigned       W_DATA   = 32,
    parameter logic [W_ADDR-1:0] ALU_BASE = 32'h0000_0000,
    parameter logic [W_ADDR-1:0] MUL_BASE = 32'h0001_0000,
    parameter logic [W_ADDR-1:0] OFS_A    = 'h00,
    parameter logic [W_ADDR-1:0] OFS_B    = 'h04,
    parameter logic [W_ADDR-1:0] OFS_CTRL = 'h08,
    parameter logic [W_ADDR-1:0] OFS_STAT = 'h0C,
    parameter logic [W_ADDR-1:0] OFS_RES  = 'h10,
    parameter int unsigned       DONE_BIT = 0,
    parameter int unsigned       POLL_MAX = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_target,
    input  logic [3:0]        req_op,
    input  logic [W_DATA-1:0] req_a,
    input  logic [W_DATA-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic [W_ADDR-1:0] o_HADDR,
    output logic [1:0]        o_HTRANS,
    output logic              o_HWRITE,
    output logic [2:0]        o_HSIZE,
    output logic [2:0]        o_HBURST,
    output logic [W_DATA-1:0] o_HWDATA,
    input  logic [W_DATA-1:0] i_HRDATA,
    input  logic [1:0]        i_HRESP,
    input  logic              i_HREADY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_BUS       = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [2:0] STEP_STAT     = 3'd3;
    localparam logic [2:0] STEP_RES      = 3'd4;
    localparam logic [7:0] POLL_LIMIT    = POLL_MAX[7:0];

    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [7:0]          poll_cnt_q, poll_cnt_d;
    logic                tgt_q, tgt_d;
    logic [3:0]          op_q, op_d;
    logic [W_DATA-1:0]   a_q, a_d;
    logic [W_DATA-1:0]   b_q, b_d;
    logic [W_ADDR-1:0]   haddr_q, haddr_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic [W_DATA-1:0]   hwdata_q, hwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [W_DATA-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_err_q, rsp_err_d;

    logic                issue;
    logic [2:0]          next_step;

    function automatic logic [W_ADDR-1:0] addr_of(input logic tgt, input logic [2:0] step);
        logic [W_ADDR-1:0] ofs;
        case (step)
            3'd0:    ofs = OFS_A;
            3'd1:    ofs = OFS_B;
            3'd2:    ofs = OFS_CTRL;
            3'd3:    ofs = OFS_STAT;
            default: ofs = OFS_RES;
        endcase
        return (tgt ? MUL_BASE : ALU_BASE) + ofs;
    endfunction

    // CTRL word carries the opcode above the start bit.
    function automatic logic [W_DATA-1:0] wdata_of(input logic [2:0] step, input logic [W_DATA-1:0] a,
                                                   input logic [W_DATA-1:0] b, input logic [3:0] op);
        case (step)
            3'd0:    return a;
            3'd1:    return b;
            3'd2:    return {{(W_DATA-5){1'b0}}, op, 1'b1};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        step_d      = step_q;
        poll_cnt_d  = poll_cnt_q;
        tgt_d       = tgt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        issue       = 1'b0;
        next_step   = step_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tgt_d      = req_target;
                    op_d       = req_op;
                    a_d        = req_a;
                    b_d        = req_b;
                    step_d     = 3'd0;
                    poll_cnt_d = 8'd0;
                    haddr_d    = addr_of(req_target, 3'd0);
                    htrans_d   = HTRANS_NONSEQ;
                    hwrite_d   = 1'b1;
                    hwdata_d   = req_a;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (i_HREADY) begin
                    if (i_HRESP == HRESP_ERROR) begin
                        rsp_err_d   = ERR_BUS;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (step_q < STEP_STAT) begin
                        issue     = 1'b1;
                        next_step = step_q + 3'd1;
                    end else if (step_q == STEP_STAT) begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        if (i_HRDATA[DONE_BIT]) begin
                            issue     = 1'b1;
                            next_step = STEP_RES;
                        end else if (poll_cnt_d == POLL_LIMIT) begin
                            rsp_err_d   = ERR_TIMEOUT;
                            rsp_data_d  = '0;
                            rsp_valid_d = 1'b1;
                            state_d     = S_RESP;
                        end else begin
                            issue     = 1'b1;
                            next_step = STEP_STAT;
                        end
                    end else begin
                        rsp_err_d   = ERR_OK;
                        rsp_data_d  = i_HRDATA;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            step_d   = next_step;
            haddr_d  = addr_of(tgt_q, next_step);
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = (next_step < STEP_STAT);
            hwdata_d = wdata_of(next_step, a_q, b_q, op_q);
            state_d  = S_ADDR;
        end
    end

    // Reset abandons any in-flight transfer by forcing HTRANS back to IDLE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
            state_q     <= S_IDLE;
            step_q      <= 3'd0;
            poll_cnt_q  <= 8'd0;
            tgt_q       <= 1'b0;
            op_q        <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            poll_cnt_q  <= poll_cnt_d;
            tgt_q       <= tgt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign o_HADDR   = haddr_q;
    assign o_HTRANS  = htrans_q;
    assign o_HWRITE  = hwrite_q;
    assign o_HWDATA  = hwdata_q;
    assign o_HSIZE   = 3'b010;
    assign o_HBURST  = 3'b000;

endmodule
